uart_rx: RTL and testbench

UART_RX -- requirements
Module: uart_rx

---
 rtl/uart_rx.sv | 131 +++++++++++++
 tb/tb_uart_rx.sv | 204 ++++++++++++++++++++
 2 files changed

// File: rtl/uart_rx.sv
// 8N1 UART receiver: 2-flop input synchronizer, mid-bit sampling, framing-error detection
// with a BREAK state that waits out a held-low line.
module uart_rx #(
    parameter int CLK_FREQ = 50_000_000,
    parameter int BAUD     = 9600
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       rx,
    output logic [7:0] rx_data,
    output logic       rx_valid,
    output logic       rx_busy,
    output logic       frame_err
);
    localparam int CLKS_PER_BIT = CLK_FREQ / BAUD;
    localparam int HALF_BIT     = CLKS_PER_BIT / 2;
    localparam int CW           = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [CW-1:0] C_LAST = CW'(CLKS_PER_BIT - 1);
    localparam logic [CW-1:0] C_MID  = CW'(HALF_BIT - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_STOP,
        S_BREAK
    } state_t;

    state_t          r_state;
    state_t          w_state_next;
    logic            r_rx_meta;
    logic            r_rx_s;
    logic [CW-1:0]   r_cnt;
    logic [CW-1:0]   w_cnt_next;
    logic [2:0]      r_idx;
    logic [2:0]      w_idx_next;
    logic [7:0]      r_shift;
    logic [7:0]      w_shift_next;
    logic [7:0]      r_data;
    logic [7:0]      w_data_next;
    logic            r_valid;
    logic            w_valid_next;
    logic            r_ferr;
    logic            w_ferr_next;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_rx_meta <= 1'b1;
            r_rx_s    <= 1'b1;
            r_state   <= S_IDLE;
            r_cnt     <= '0;
            r_idx     <= '0;
            r_shift   <= '0;
            r_data    <= '0;
            r_valid   <= 1'b0;
            r_ferr    <= 1'b0;
        end else begin
            r_rx_meta <= rx;
            r_rx_s    <= r_rx_meta;
            r_state   <= w_state_next;
            r_cnt     <= w_cnt_next;
            r_idx     <= w_idx_next;
            r_shift   <= w_shift_next;
            r_data    <= w_data_next;
            r_valid   <= w_valid_next;
            r_ferr    <= w_ferr_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        w_cnt_next   = r_cnt;
        w_idx_next   = r_idx;
        w_shift_next = r_shift;
        w_data_next  = r_data;
        w_valid_next = 1'b0;
        w_ferr_next  = 1'b0;
        case (r_state)
            S_IDLE: begin
                w_cnt_next = '0;
                if (!r_rx_s) w_state_next = S_START;
            end
            S_START: begin
                // Re-check the line at the middle of the start bit to reject glitches.
                if (r_cnt == C_MID) begin
                    w_cnt_next   = '0;
                    w_idx_next   = '0;
                    w_state_next = r_rx_s ? S_IDLE : S_DATA;
                end else begin
                    w_cnt_next = r_cnt + CW'(1);
                end
            end
            S_DATA: begin
                if (r_cnt == C_LAST) begin
                    w_shift_next[r_idx] = r_rx_s;
                    w_cnt_next          = '0;
                    if (r_idx == 3'd7) w_state_next = S_STOP;
                    else               w_idx_next   = r_idx + 3'd1;
                end else begin
                    w_cnt_next = r_cnt + CW'(1);
                end
            end
            S_STOP: begin
                if (r_cnt == C_LAST) begin
                    w_cnt_next = '0;
                    if (r_rx_s) begin
                        w_data_next  = r_shift;
                        w_valid_next = 1'b1;
                        w_state_next = S_IDLE;
                    end else begin
                        w_ferr_next  = 1'b1;
                        w_state_next = S_BREAK;
                    end
                end else begin
                    w_cnt_next = r_cnt + CW'(1);
                end
            end
            S_BREAK: begin
                w_cnt_next = '0;
                if (r_rx_s) w_state_next = S_IDLE;
            end
            default: w_state_next = S_IDLE;
        endcase
    end

    assign rx_data   = r_data;
    assign rx_valid  = r_valid;
    assign frame_err = r_ferr;
    assign rx_busy   = (r_state != S_IDLE);

endmodule

// File: tb/tb_uart_rx.sv
// Directed bench for uart_rx: table of single frames plus hand-written sequences for
// back-to-back frames, break after a bad stop bit, start-bit glitch and mid-frame reset.
module tb_uart_rx;
    localparam int CPB = 16;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       rx  = 1'b1;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic       rx_busy;
    logic       frame_err;

    uart_rx #(.CLK_FREQ(1600), .BAUD(100)) dut (
        .clk      (clk),
        .rst      (rst),
        .rx       (rx),
        .rx_data  (rx_data),
        .rx_valid (rx_valid),
        .rx_busy  (rx_busy),
        .frame_err(frame_err)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int         tests = 0;
    int         fails = 0;
    int         n_valid = 0;
    int         n_ferr = 0;
    int         n_viol = 0;
    int         valid_cyc = 0;
    logic [7:0] got_q[$];
    logic [7:0] prev_data = 8'h00;
    logic       prev_valid = 1'b0;
    logic       prev_ferr = 1'b0;

    // Pulse/hold monitor, sampled 1 time unit after each rising edge.
    always @(posedge clk) begin
        #1;
        if (!rst) begin
            prev_data  = rx_data;
            prev_valid = 1'b0;
            prev_ferr  = 1'b0;
        end else begin
            if (rx_valid) begin
                n_valid++;
                got_q.push_back(rx_data);
                valid_cyc = cyc;
            end
            if (frame_err) n_ferr++;
            if (rx_valid && frame_err) n_viol++;
            if ((rx_valid && prev_valid) || (frame_err && prev_ferr)) n_viol++;
            if ((rx_data != prev_data) && !rx_valid) n_viol++;
            prev_data  = rx_data;
            prev_valid = rx_valid;
            prev_ferr  = frame_err;
        end
    end

    task automatic check(input string name, input int act, input int exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic send_bit(input logic b);
        rx = b;
        repeat (CPB) @(negedge clk);
    endtask

    task automatic send_frame(input logic [7:0] d, input logic stop);
        send_bit(1'b0);
        for (int i = 0; i < 8; i++) send_bit(d[i]);
        send_bit(stop);
    endtask

    typedef struct {
        logic [7:0] data;
        logic       stop;
        int         exp_valid;
        int         exp_ferr;
        logic [7:0] exp_data;
    } vec_t;

    vec_t vecs[5];

    initial begin
        int nv0, nf0, start_cyc, lat;
        vecs[0] = '{8'hA3, 1'b1, 1, 0, 8'hA3};
        vecs[1] = '{8'h3C, 1'b1, 1, 0, 8'h3C};
        vecs[2] = '{8'h55, 1'b0, 0, 1, 8'h3C};
        vecs[3] = '{8'h81, 1'b1, 1, 0, 8'h81};
        vecs[4] = '{8'h7E, 1'b1, 1, 0, 8'h7E};

        repeat (3) @(negedge clk);
        #1;
        check("reset_rx_data", rx_data, 8'h00);
        check("reset_rx_valid", rx_valid, 0);
        check("reset_rx_busy", rx_busy, 0);
        check("reset_frame_err", frame_err, 0);
        @(negedge clk);
        rst = 1'b1;
        repeat (4) @(negedge clk);

        for (int v = 0; v < 5; v++) begin
            nv0 = n_valid;
            nf0 = n_ferr;
            start_cyc = cyc;
            send_frame(vecs[v].data, vecs[v].stop);
            rx = 1'b1;
            repeat (2 * CPB) @(negedge clk);
            $display("[TB] vec %0d data=0x%02h stop=%0b -> valid=%0d ferr=%0d rx_data=0x%02h",
                     v, vecs[v].data, vecs[v].stop, n_valid - nv0, n_ferr - nf0, rx_data);
            check($sformatf("vec%0d_valid_cnt", v), n_valid - nv0, vecs[v].exp_valid);
            check($sformatf("vec%0d_ferr_cnt", v), n_ferr - nf0, vecs[v].exp_ferr);
            check($sformatf("vec%0d_rx_data", v), rx_data, vecs[v].exp_data);
            check($sformatf("vec%0d_busy_idle", v), rx_busy, 0);
            if (v == 0) begin
                lat = valid_cyc - start_cyc;
                check("latency_in_window", int'(lat >= 148 && lat <= 160), 1);
            end
        end

        // Back-to-back frames, no idle gap.
        got_q.delete();
        send_frame(8'h00, 1'b1);
        send_frame(8'hFF, 1'b1);
        rx = 1'b1;
        repeat (2 * CPB) @(negedge clk);
        $display("[TB] back-to-back -> %0d bytes", got_q.size());
        check("b2b_count", got_q.size(), 2);
        if (got_q.size() >= 2) begin
            check("b2b_first", got_q[0], 8'h00);
            check("b2b_second", got_q[1], 8'hFF);
        end

        // Bad stop bit followed by a held-low line.
        nv0 = n_valid;
        nf0 = n_ferr;
        send_frame(8'h55, 1'b0);
        repeat (3 * CPB) @(negedge clk);
        #1;
        $display("[TB] break -> ferr=%0d busy=%0b rx_data=0x%02h", n_ferr - nf0, rx_busy, rx_data);
        check("break_busy_low_line", rx_busy, 1);
        check("break_ferr_cnt", n_ferr - nf0, 1);
        check("break_valid_cnt", n_valid - nv0, 0);
        check("break_rx_data_held", rx_data, 8'hFF);
        @(negedge clk);
        rx = 1'b1;
        repeat (4) @(negedge clk);
        check("break_busy_released", rx_busy, 0);

        // Start-bit glitch of CPB/4 cycles.
        nv0 = n_valid;
        nf0 = n_ferr;
        rx = 1'b0;
        repeat (CPB / 4) @(negedge clk);
        #1;
        check("glitch_busy_start", rx_busy, 1);
        rx = 1'b1;
        repeat (CPB / 2) @(negedge clk);
        #1;
        check("glitch_idle_by_midbit", rx_busy, 0);
        repeat (CPB) @(negedge clk);
        $display("[TB] glitch -> valid=%0d ferr=%0d", n_valid - nv0, n_ferr - nf0);
        check("glitch_valid_cnt", n_valid - nv0, 0);
        check("glitch_ferr_cnt", n_ferr - nf0, 0);

        // Reset during data bit 4, then a clean frame.
        nv0 = n_valid;
        nf0 = n_ferr;
        send_bit(1'b0);
        for (int i = 0; i < 4; i++) send_bit(1'(8'h3C >> i));
        rx = 1'b1;
        repeat (CPB / 2) @(negedge clk);
        rst = 1'b0;
        #1;
        check("midrst_rx_data", rx_data, 8'h00);
        check("midrst_busy", rx_busy, 0);
        check("midrst_valid", rx_valid, 0);
        check("midrst_ferr", frame_err, 0);
        repeat (10) @(negedge clk);
        rst = 1'b1;
        repeat (4) @(negedge clk);
        check("midrst_no_valid", n_valid - nv0, 0);
        check("midrst_no_ferr", n_ferr - nf0, 0);
        send_frame(8'h3C, 1'b1);
        rx = 1'b1;
        repeat (2 * CPB) @(negedge clk);
        $display("[TB] after reset -> valid=%0d rx_data=0x%02h", n_valid - nv0, rx_data);
        check("midrst_next_valid", n_valid - nv0, 1);
        check("midrst_next_data", rx_data, 8'h3C);

        check("pulse_rules_violations", n_viol, 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
